adder_word_sequencer: RTL and testbench



---
 rtl/adder_word_sequencer.sv | 147 ++++++++++++++
 tb/tb_adder_word_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_word_sequencer.sv
// Streams multi-word operands through one WIDTH-bit adder slice, LSW first,
// chaining carry between words and restarting it at every operand boundary.
module adder_word_sequencer #(
  parameter int WIDTH     = 8,
  parameter int NUM_WORDS = 4,
  localparam int IDX_W    = $clog2(NUM_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cin,
  input  logic             in_last,
  output logic [WIDTH-1:0] adder_x,
  output logic [WIDTH-1:0] adder_y,
  output logic             adder_carry_in,
  input  logic             adder_carry_output_bit,
  input  logic [WIDTH-1:0] adder_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_last,
  output logic             out_trunc,
  output logic [IDX_W-1:0] out_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {FIRST, MID} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] word_idx, word_idx_nxt;
  logic             carry_q;

  logic             vld_p0;
  logic [WIDTH-1:0] op_x_p0;
  logic [WIDTH-1:0] op_y_p0;
  logic             op_cin_p0;
  logic             op_last_p0;
  logic             op_trunc_p0;
  logic [IDX_W-1:0] op_idx_p0;

  logic accept;
  logic adv;
  logic op_end;

  // The first word of an operand takes the external carry; later words chain.
  function automatic logic sel_carry_in(input logic [IDX_W-1:0] idx,
                                        input logic cin, input logic chained);
    return (idx == '0) ? cin : chained;
  endfunction

  assign adv      = vld_p0 && (!out_valid || out_ready);
  assign in_ready = !rst && (!vld_p0 || adv);
  assign accept   = in_valid && in_ready;
  assign op_end   = op_last_p0 || op_trunc_p0;

  assign adder_x        = vld_p0 ? op_x_p0 : '0;
  assign adder_y        = vld_p0 ? op_y_p0 : '0;
  assign adder_carry_in = vld_p0 && sel_carry_in(op_idx_p0, op_cin_p0, carry_q);

  always_comb begin
    state_nxt    = state;
    word_idx_nxt = word_idx;
    if (accept) begin
      case (state)
        FIRST: begin
          if (!in_last) begin
            state_nxt    = MID;
            word_idx_nxt = word_idx + 1'b1;
          end
        end
        MID: begin
          if (in_last || word_idx == LAST_IDX) begin
            state_nxt    = FIRST;
            word_idx_nxt = '0;
          end else begin
            word_idx_nxt = word_idx + 1'b1;
          end
        end
        default: begin
          state_nxt    = FIRST;
          word_idx_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FIRST;
      word_idx <= '0;
    end else begin
      state    <= state_nxt;
      word_idx <= word_idx_nxt;
    end
  end

  // Stage p0: registered operand word feeding the slice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
    end else if (accept) begin
      vld_p0 <= 1'b1;
    end else if (adv) begin
      vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_x_p0     <= in_x;
      op_y_p0     <= in_y;
      op_cin_p0   <= in_cin;
      op_last_p0  <= in_last;
      op_trunc_p0 <= !in_last && (word_idx == LAST_IDX);
      op_idx_p0   <= word_idx;
    end
  end

  // Stage p1: captured slice result; fields hold while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_last  <= 1'b0;
      out_trunc <= 1'b0;
      out_idx   <= '0;
      carry_q   <= 1'b0;
    end else if (adv) begin
      out_valid <= 1'b1;
      out_sum   <= adder_sum;
      out_carry <= adder_carry_output_bit;
      out_last  <= op_end;
      out_trunc <= op_trunc_p0;
      out_idx   <= op_idx_p0;
      carry_q   <= op_end ? 1'b0 : adder_carry_output_bit;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_word_sequencer.sv
// Bench for adder_word_sequencer: behavioural 8-bit slice, scoreboard queue
// filled by the stimulus process and drained by an output monitor.
module tb_adder_word_sequencer;

  localparam int WIDTH     = 8;
  localparam int NUM_WORDS = 4;
  localparam int IDX_W     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             in_cin;
  logic             in_last;
  logic [WIDTH-1:0] adder_x;
  logic [WIDTH-1:0] adder_y;
  logic             adder_carry_in;
  logic             adder_carry_output_bit;
  logic [WIDTH-1:0] adder_sum;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_last;
  logic             out_trunc;
  logic [IDX_W-1:0] out_idx;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             last;
    logic             trunc;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic [WIDTH:0] slice_full;
  assign slice_full = (WIDTH+1)'(adder_x) + (WIDTH+1)'(adder_y) + (WIDTH+1)'(adder_carry_in);
  assign adder_sum = slice_full[WIDTH-1:0];
  assign adder_carry_output_bit = slice_full[WIDTH];

  adder_word_sequencer #(.WIDTH(WIDTH), .NUM_WORDS(NUM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_cin(in_cin), .in_last(in_last),
    .adder_x(adder_x), .adder_y(adder_y), .adder_carry_in(adder_carry_in),
    .adder_carry_output_bit(adder_carry_output_bit), .adder_sum(adder_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_last(out_last),
    .out_trunc(out_trunc), .out_idx(out_idx)
  );

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got sum=%h carry=%b idx=%0d, none expected",
                 out_sum, out_carry, out_idx);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({out_sum, out_carry, out_last, out_trunc, out_idx} !== e) begin
          errors++;
          $display("FAIL word got sum=%h carry=%b last=%b trunc=%b idx=%0d want sum=%h carry=%b last=%b trunc=%b idx=%0d",
                   out_sum, out_carry, out_last, out_trunc, out_idx,
                   e.sum, e.carry, e.last, e.trunc, e.idx);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic cin, input logic last, input logic push,
                       input logic [WIDTH-1:0] es, input logic ec, input logic el,
                       input logic et, input logic [IDX_W-1:0] ei);
    in_x     = x;
    in_y     = y;
    in_cin   = cin;
    in_last  = last;
    in_valid = 1'b1;
    if (push) q.push_back('{sum: es, carry: ec, last: el, trunc: et, idx: ei});
  endtask

  task automatic wait_accept();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=%b want 1 within 50 cycles", in_ready);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_sum"}, 32'(out_sum), 0);
    chk({tag, "_out_flags"}, 32'({out_carry, out_last, out_trunc}), 0);
    chk({tag, "_out_idx"}, 32'(out_idx), 0);
    chk({tag, "_adder"}, 32'({adder_x, adder_y, adder_carry_in}), 0);
  endtask

  logic [WIDTH-1:0] t4_sum [5] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00};
  logic [IDX_W-1:0] t4_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
    in_cin = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // single word 1+2, latency of one cycle after accept
    drive(8'h01, 8'h02, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 2'd0);
    wait_accept();
    @(negedge clk);
    chk("lat_before", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat_after", 32'(out_valid), 1);
    @(posedge clk); #1;

    // 0x01FF + 0x0001, back to back
    drive(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
    wait_accept();
    drive(8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 2'd1);
    wait_accept();
    chk("b2b_word0_out", 32'({out_valid, out_idx, out_sum}), 32'({1'b1, 2'd0, 8'h00}));

    // initial carry on first word only
    drive(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
    wait_accept();
    drive(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 2'd1);
    wait_accept();
    repeat (3) @(posedge clk);
    #1;

    // backpressure: two words buffer, third stalls until release
    out_ready = 1'b0;
    drive(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
    wait_accept();
    drive(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1);
    wait_accept();
    drive(8'h05, 8'h02, 1'b0, 1'b1, 1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 2'd2);
    @(negedge clk);
    chk("bp_in_ready_a", 32'(in_ready), 0);
    chk("bp_hold_a", 32'({out_valid, out_sum, out_carry, out_idx}), 32'({1'b1, 8'h00, 1'b1, 2'd0}));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_in_ready_b", 32'(in_ready), 0);
    chk("bp_hold_b", 32'({out_valid, out_sum, out_carry, out_idx}), 32'({1'b1, 8'h00, 1'b1, 2'd0}));
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept();
    repeat (3) @(posedge clk);
    #1;

    // truncation at NUM_WORDS, then a fresh operand restarts at idx 0
    for (int i = 0; i < 5; i++) begin
      drive(8'hFF, 8'h01, 1'b0, (i == 4), 1'b1, t4_sum[i], 1'b1,
            (i >= 3), (i == 3), t4_idx[i]);
      wait_accept();
    end
    repeat (3) @(posedge clk);
    #1;

    // reset mid-operand discards the pending word and the chained carry
    drive(8'hFF, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 2'd0);
    wait_accept();
    repeat (2) @(posedge clk);
    #1;
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    wait_accept();
    rst = 1'b1;
    @(negedge clk);
    chk_zero_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    drive(8'h01, 8'h01, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 2'd0);
    wait_accept();

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
